stream_to_hs_fifo: RTL

STREAM_TO_HS_FIFO -- requirements
Module: stream_to_hs_fifo

---
 rtl/stream_to_hs_fifo_if.sv | 19 +
 rtl/stream_to_hs_fifo.sv | 43 ++++
 2 files changed

// File: rtl/stream_to_hs_fifo_if.sv
// stream_to_hs_fifo_if: stream input and ap_vld/ap_ack handshake output bundle
interface stream_to_hs_fifo_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] inStream_tdata;
    logic                  inStream_tvalid;
    logic                  inStream_tready;
    logic [DATA_WIDTH-1:0] out_hs;
    logic                  out_hs_ap_vld;
    logic                  out_hs_ap_ack;
    modport slave (
        input  inStream_tdata, inStream_tvalid, out_hs_ap_ack,
        output inStream_tready, out_hs, out_hs_ap_vld
    );
    modport master (
        output inStream_tdata, inStream_tvalid, out_hs_ap_ack,
        input  inStream_tready, out_hs, out_hs_ap_vld
    );
endinterface

// File: rtl/stream_to_hs_fifo.sv
// stream_to_hs_fifo: stream-to-handshake FIFO whose head output comes only from stored state
module stream_to_hs_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 flush,
    stream_to_hs_fifo_if.slave   bus,
    output logic [CNT_WIDTH-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    assign bus.inStream_tready = aresetn && !flush && (level < CNT_WIDTH'(DEPTH));
    assign bus.out_hs_ap_vld   = level != '0;
    assign bus.out_hs          = mem[rd_ptr];
    assign push = bus.inStream_tvalid && bus.inStream_tready;
    assign pop  = bus.out_hs_ap_vld && bus.out_hs_ap_ack && !flush;
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        end
    end
    // storage is deliberately left out of reset so it maps to plain register arrays
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.inStream_tdata;
    end
endmodule
